nand_ram16: RTL and testbench

//   16-word x 16-bit random-access memory for the from-NAND CPU datapath.

---
 rtl/nand_ram16_pkg.sv | 22 ++
 rtl/nand_ram16_if.sv | 30 +++
 rtl/nand_ram16_reg16.sv | 26 ++
 rtl/nand_ram16.sv | 34 +++
 tb/tb_nand_ram16.sv | 115 +++++++++++
 5 files changed

// File: rtl/nand_ram16_pkg.sv
// rtl/nand_ram16_pkg.sv - shared widths, types and decode helper for nand_ram16
// Purpose: word/address widths and types used by the RAM, its bus interface
//          and the per-word register.
// Contents: WORD_W, ADDR_W, DEPTH, word_t, addr_t, decode_onehot().
package nand_ram16_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // 4-to-16 one-hot decode; every address maps to exactly one word.
  function automatic logic [DEPTH-1:0] decode_onehot(input addr_t a);
    logic [DEPTH-1:0] sel;
    sel    = '0;
    sel[a] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/nand_ram16_if.sv
// rtl/nand_ram16_if.sv - CPU-side address/data bus of nand_ram16
// Purpose: groups the RAM access signals.
// Signals: d_in    write data
//          address word select for read and write
//          rw      1 = write d_in at next rising edge, 0 = read only
//          d_out   combinational read data, mem[address]
// Modports: master (CPU side), slave (RAM side).
interface nand_ram16_if;
  import nand_ram16_pkg::*;

  word_t d_in;
  addr_t address;
  logic  rw;
  word_t d_out;

  modport master (
    output d_in,
    output address,
    output rw,
    input  d_out
  );

  modport slave (
    input  d_in,
    input  address,
    input  rw,
    output d_out
  );

endinterface

// File: rtl/nand_ram16_reg16.sv
// rtl/nand_ram16_reg16.sv - 16-bit register with synchronous reset and load enable
// Purpose: storage for one RAM word.
// Ports: clk   rising-edge clock
//        reset synchronous active-high clear (wins over load)
//        load  capture d on the next rising edge
//        d     data in
//        q     stored word
module nand_ram16_reg16
  import nand_ram16_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t d,
  output word_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nand_ram16.sv
// rtl/nand_ram16.sv - 16 x 16-bit RAM, synchronous write, combinational read
// Purpose: data store for the CPU datapath.
// Ports: clk   rising-edge clock
//        reset synchronous active-high, clears all 16 words
//        bus   nand_ram16_if.slave (d_in, address, rw, d_out)
module nand_ram16
  import nand_ram16_pkg::*;
(
  input logic         clk,
  input logic         reset,
  nand_ram16_if.slave bus
);

  logic [DEPTH-1:0] load;
  word_t            words [DEPTH];

  // Only the addressed word is enabled, and only when rw requests a write.
  assign load = bus.rw ? decode_onehot(bus.address) : '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    nand_ram16_reg16 u_word (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .d     (bus.d_in),
      .q     (words[i])
    );
  end

  // Unclocked read: d_out follows address within the same cycle and shows
  // the old word until the write edge.
  assign bus.d_out = words[bus.address];

endmodule

// File: tb/tb_nand_ram16.sv
// tb/tb_nand_ram16.sv - directed self-checking bench for nand_ram16
module tb_nand_ram16;
  import nand_ram16_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  nand_ram16_if bus ();

  nand_ram16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    bus.address = a;
    bus.d_in    = d;
    bus.rw      = 1'b1;
    step();
    bus.rw      = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.d_out, exp);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.rw      = 1'b0;
    bus.d_in    = '0;
    bus.address = '0;
    @(negedge clk);

    // 1: reset two cycles, every word reads zero
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_check($sformatf("reset_a%0d", i), 4'(i), 16'h0000);
    end

    // 2: write addr 0, read back next cycle
    write_word(4'd0, 16'b1001001110111101);
    read_check("wr_a0", 4'd0, 16'h93BD);

    // 3: write addr 3, addr 0 undisturbed
    write_word(4'd3, 16'hFFBD);
    read_check("nodist_a0", 4'd0, 16'h93BD);
    read_check("wr_a3", 4'd3, 16'hFFBD);

    // 4: hold with rw=0 and changing d_in
    write_word(4'd5, 16'h1234);
    bus.address = 4'd5;
    bus.d_in    = 16'hAAAA;
    bus.rw      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      read_check($sformatf("hold_a5_e%0d", i), 4'd5, 16'h1234);
    end

    // 5: read during write, then reset beats write
    bus.address = 4'd7;
    bus.d_in    = 16'h0F0F;
    bus.rw      = 1'b1;
    #1;
    check("rdw_before", bus.d_out, 16'h0000);
    step();
    check("rdw_after", bus.d_out, 16'h0F0F);
    reset    = 1'b1;
    bus.d_in = 16'h5555;
    bus.rw   = 1'b1;
    step();
    reset  = 1'b0;
    bus.rw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      read_check($sformatf("rst_pri_a%0d", i), 4'(i), 16'h0000);
    end

    // 6: walking one across all words
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i), 16'h0001 << i);
    end
    for (int i = 0; i < 16; i++) begin
      read_check($sformatf("walk_a%0d", i), 4'(i), 16'h0001 << i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
